ssf_io_ctrl: RTL and testbench

//  Stream I/O controller between the proc_fx I/O strobes (addr_dec one-hot req_in/out_en) and

---
 rtl/ssf_io_ctrl.sv | 132 +++++++++++++
 tb/tb_ssf_io_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ssf_io_ctrl.sv
// Stream I/O controller: per-port input FIFOs served on processor read strobes,
// per-port output holding registers with valid/ready handoff, sticky error flags.
module ssf_io_ctrl #(
   parameter int NUBITS = 32,
   parameter int NUIOIN = 2,
   parameter int NUIOOU = 2,
   parameter int FDEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUIOIN*NUBITS-1:0]   s_data,
   input  logic [NUIOIN-1:0]          s_valid,
   output logic [NUIOIN-1:0]          s_ready,
   input  logic [NUIOIN-1:0]          req_in,
   output logic signed [NUBITS-1:0]   io_in,
   input  logic [NUIOOU-1:0]          out_en,
   input  logic signed [NUBITS-1:0]   io_out,
   output logic [NUIOOU*NUBITS-1:0]   m_data,
   output logic [NUIOOU-1:0]          m_valid,
   input  logic [NUIOOU-1:0]          m_ready,
   output logic [NUIOIN-1:0]          underrun,
   output logic [NUIOOU-1:0]          overrun,
   output logic                       multi_err,
   input  logic                       clr_err
);

   localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
   localparam int CW = $clog2(FDEPTH + 1);
   localparam int SW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;

   logic [NUBITS-1:0] mem  [NUIOIN][FDEPTH];
   logic [PW-1:0]     wptr [NUIOIN];
   logic [PW-1:0]     rptr [NUIOIN];
   logic [CW-1:0]     cnt  [NUIOIN];

   logic [SW-1:0]     sel;
   logic              req_any;
   logic [NUIOIN-1:0] push;
   logic [NUIOIN-1:0] pop;
   logic [NUIOIN-1:0] under_ev;
   logic [NUIOOU-1:0] over_ev;
   logic              multi_ev;

   // Lowest-index requester wins; extra strobe bits only raise multi_err.
   always_comb begin
      sel     = '0;
      req_any = 1'b0;
      for (int unsigned i = 0; i < NUIOIN; i++) begin
         if (req_in[i] && !req_any) begin
            sel     = SW'(i);
            req_any = 1'b1;
         end
      end
   end

   always_comb begin
      s_ready  = '0;
      push     = '0;
      pop      = '0;
      under_ev = '0;
      for (int unsigned k = 0; k < NUIOIN; k++) begin
         s_ready[k]  = (cnt[k] != CW'(FDEPTH));
         push[k]     = s_valid[k] & s_ready[k];
         pop[k]      = req_any && (sel == SW'(k)) && (cnt[k] != '0);
         under_ev[k] = req_any && (sel == SW'(k)) && (cnt[k] == '0);
      end
   end

   always_comb begin
      io_in = '0;
      if (req_any && (cnt[sel] != '0))
         io_in = mem[sel][rptr[sel]];
   end

   always_comb begin
      multi_ev = (|(req_in & (req_in - NUIOIN'(1)))) | (|(out_en & (out_en - NUIOOU'(1))));
      over_ev  = out_en & m_valid & ~m_ready;
   end

   // Storage is not reset: pointers and counts define what is live.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < NUIOIN; k++)
         if (push[k])
            mem[k][wptr[k]] <= s_data[k*NUBITS +: NUBITS];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < NUIOIN; k++) begin
            wptr[k] <= '0;
            rptr[k] <= '0;
            cnt[k]  <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NUIOIN; k++) begin
            if (push[k]) wptr[k] <= wptr[k] + PW'(1);
            if (pop[k])  rptr[k] <= rptr[k] + PW'(1);
            cnt[k] <= cnt[k] + CW'(push[k]) - CW'(pop[k]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_data  <= '0;
         m_valid <= '0;
      end else begin
         for (int unsigned k = 0; k < NUIOOU; k++) begin
            if (out_en[k]) begin
               m_data[k*NUBITS +: NUBITS] <= io_out;
               m_valid[k]                 <= 1'b1;
            end else if (m_ready[k]) begin
               m_valid[k] <= 1'b0;
            end
         end
      end
   end

   // A new error event in the clearing cycle takes priority over clr_err.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         underrun  <= '0;
         overrun   <= '0;
         multi_err <= 1'b0;
      end else begin
         underrun  <= (clr_err ? '0 : underrun) | under_ev;
         overrun   <= (clr_err ? '0 : overrun) | over_ev;
         multi_err <= (clr_err ? 1'b0 : multi_err) | multi_ev;
      end
   end

endmodule

// File: tb/tb_ssf_io_ctrl.sv
// Directed self-checking bench for ssf_io_ctrl (default 32-bit, 2 in / 2 out, depth 4).
module tb_ssf_io_ctrl;

   logic               clk = 1'b0;
   logic               rst;
   logic [63:0]        s_data;
   logic [1:0]         s_valid;
   logic [1:0]         s_ready;
   logic [1:0]         req_in;
   logic signed [31:0] io_in;
   logic [1:0]         out_en;
   logic signed [31:0] io_out;
   logic [63:0]        m_data;
   logic [1:0]         m_valid;
   logic [1:0]         m_ready;
   logic [1:0]         underrun;
   logic [1:0]         overrun;
   logic               multi_err;
   logic               clr_err;

   int n_checks = 0;
   int n_fail   = 0;

   ssf_io_ctrl #(.NUBITS(32), .NUIOIN(2), .NUIOOU(2), .FDEPTH(4)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .req_in(req_in), .io_in(io_in), .out_en(out_en), .io_out(io_out),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .underrun(underrun),
      .overrun(overrun), .multi_err(multi_err), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_flags;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; s_valid = 2'b11; req_in = 2'b01; s_data = {32'hAA, 32'hBB};
      tick(); tick();
      n_checks++; if (s_ready !== 2'b11) begin n_fail++; $display("FAIL reset_s_ready got %b exp 11", s_ready); end
      n_checks++; if (m_valid !== 2'b00) begin n_fail++; $display("FAIL reset_m_valid got %b exp 00", m_valid); end
      n_checks++; if ({underrun, overrun, multi_err} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0", {underrun, overrun, multi_err}); end
      n_checks++; if (io_in !== 32'sd0) begin n_fail++; $display("FAIL reset_io_in got %h exp 0", io_in); end
      n_checks++; if (m_data !== 64'd0) begin n_fail++; $display("FAIL reset_m_data got %h exp 0", m_data); end
      s_valid = 2'b00; req_in = 2'b00;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_fill_drain;
      logic [31:0] d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      for (int i = 0; i < 4; i++) begin
         s_data[31:0] = d[i]; s_valid = 2'b01;
         tick();
      end
      s_valid = 2'b00;
      n_checks++; if (s_ready[0] !== 1'b0) begin n_fail++; $display("FAIL full_s_ready got %b exp 0", s_ready[0]); end
      for (int i = 0; i < 4; i++) begin
         req_in = 2'b01; #1;
         n_checks++; if (io_in !== d[i]) begin n_fail++; $display("FAIL drain_%0d got %h exp %h", i, io_in, d[i]); end
         tick();
      end
      req_in = 2'b01; #1;
      n_checks++; if (io_in !== 32'sd0) begin n_fail++; $display("FAIL empty_read got %h exp 0", io_in); end
      tick();
      req_in = 2'b00;
      n_checks++; if (underrun !== 2'b01) begin n_fail++; $display("FAIL underrun0 got %b exp 01", underrun); end
      clear_flags();
      n_checks++; if (underrun !== 2'b00) begin n_fail++; $display("FAIL underrun_clr got %b exp 00", underrun); end
   endtask

   task automatic test_full_read_push;
      for (int i = 0; i < 4; i++) begin
         s_data[31:0] = 32'hA0 + 32'(i); s_valid = 2'b01;
         tick();
      end
      s_data[31:0] = 32'hEE; s_valid = 2'b01; req_in = 2'b01; #1;
      n_checks++; if (s_ready[0] !== 1'b0) begin n_fail++; $display("FAIL fullrd_s_ready got %b exp 0", s_ready[0]); end
      n_checks++; if (io_in !== 32'shA0) begin n_fail++; $display("FAIL fullrd_io_in got %h exp a0", io_in); end
      tick();
      s_valid = 2'b00; req_in = 2'b00;
      n_checks++; if (s_ready[0] !== 1'b1) begin n_fail++; $display("FAIL fullrd_rise got %b exp 1", s_ready[0]); end
      for (int i = 1; i < 4; i++) begin
         req_in = 2'b01; #1;
         n_checks++; if (io_in !== 32'shA0 + i) begin n_fail++; $display("FAIL fullrd_drain_%0d got %h exp %h", i, io_in, 32'hA0 + i); end
         tick();
      end
      req_in = 2'b01; #1;
      n_checks++; if (io_in !== 32'sd0) begin n_fail++; $display("FAIL fullrd_nopush got %h exp 0", io_in); end
      tick();
      req_in = 2'b00;
      clear_flags();
      // continuous streaming across pointer wrap: push w[i] while reading w[i-1]
      for (int i = 0; i <= 10; i++) begin
         s_valid = (i < 10) ? 2'b01 : 2'b00;
         s_data[31:0] = 32'h100 + 32'(i);
         req_in = (i > 0) ? 2'b01 : 2'b00;
         #1;
         if (i > 0) begin
            n_checks++; if (io_in !== 32'sh100 + (i - 1)) begin n_fail++; $display("FAIL wrap_%0d got %h exp %h", i, io_in, 32'h100 + (i - 1)); end
         end
         tick();
      end
      s_valid = 2'b00; req_in = 2'b00;
      n_checks++; if (underrun !== 2'b00) begin n_fail++; $display("FAIL wrap_underrun got %b exp 00", underrun); end
   endtask

   task automatic test_write_overrun;
      m_ready = 2'b00; out_en = 2'b10; io_out = -32'sd5;
      tick();
      out_en = 2'b00;
      n_checks++; if (m_data[63:32] !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL wr_data got %h exp fffffffb", m_data[63:32]); end
      n_checks++; if (m_valid !== 2'b10) begin n_fail++; $display("FAIL wr_valid got %b exp 10", m_valid); end
      n_checks++; if (overrun !== 2'b00) begin n_fail++; $display("FAIL wr_no_over got %b exp 00", overrun); end
      out_en = 2'b10; io_out = 32'sd7;
      tick();
      out_en = 2'b00;
      n_checks++; if (m_data[63:32] !== 32'd7) begin n_fail++; $display("FAIL ovr_data got %h exp 7", m_data[63:32]); end
      n_checks++; if (overrun !== 2'b10) begin n_fail++; $display("FAIL ovr_flag got %b exp 10", overrun); end
      clear_flags();
      n_checks++; if (overrun !== 2'b00) begin n_fail++; $display("FAIL ovr_clr got %b exp 00", overrun); end
      m_ready = 2'b10;
      tick();
      m_ready = 2'b00;
      n_checks++; if (m_valid !== 2'b00) begin n_fail++; $display("FAIL consume_valid got %b exp 00", m_valid); end
      n_checks++; if (m_data[63:32] !== 32'd7) begin n_fail++; $display("FAIL consume_hold got %h exp 7", m_data[63:32]); end
   endtask

   task automatic test_multi;
      s_data = {32'h66, 32'h55}; s_valid = 2'b11;
      tick();
      s_valid = 2'b00; req_in = 2'b11; #1;
      n_checks++; if (io_in !== 32'sh55) begin n_fail++; $display("FAIL multi_sel got %h exp 55", io_in); end
      tick();
      req_in = 2'b00;
      n_checks++; if (multi_err !== 1'b1) begin n_fail++; $display("FAIL multi_err got %b exp 1", multi_err); end
      req_in = 2'b10; #1;
      n_checks++; if (io_in !== 32'sh66) begin n_fail++; $display("FAIL multi_fifo1 got %h exp 66", io_in); end
      tick();
      req_in = 2'b01; #1;
      n_checks++; if (io_in !== 32'sd0) begin n_fail++; $display("FAIL multi_fifo0_empty got %h exp 0", io_in); end
      tick();
      req_in = 2'b00; out_en = 2'b11; io_out = 32'sd9;
      tick();
      out_en = 2'b00;
      n_checks++; if (m_data !== {32'd9, 32'd9}) begin n_fail++; $display("FAIL multi_wr got %h exp 9/9", m_data); end
      n_checks++; if (m_valid !== 2'b11) begin n_fail++; $display("FAIL multi_wr_valid got %b exp 11", m_valid); end
      clear_flags();
      n_checks++; if ({underrun, multi_err} !== 3'b0) begin n_fail++; $display("FAIL multi_clr got %b exp 0", {underrun, multi_err}); end
      clr_err = 1'b1; req_in = 2'b11;
      tick();
      clr_err = 1'b0; req_in = 2'b00;
      n_checks++; if (multi_err !== 1'b1) begin n_fail++; $display("FAIL clr_vs_event got %b exp 1", multi_err); end
      clear_flags();
   endtask

   task automatic test_handoff_reset;
      m_ready = 2'b01; out_en = 2'b01; io_out = 32'sh77;
      tick();
      m_ready = 2'b00; out_en = 2'b00;
      n_checks++; if (m_data[31:0] !== 32'h77) begin n_fail++; $display("FAIL handoff_data got %h exp 77", m_data[31:0]); end
      n_checks++; if (m_valid !== 2'b11) begin n_fail++; $display("FAIL handoff_valid got %b exp 11", m_valid); end
      n_checks++; if (overrun !== 2'b00) begin n_fail++; $display("FAIL handoff_over got %b exp 00", overrun); end
      for (int i = 0; i < 4; i++) begin
         s_data = {32'h1, 32'h2}; s_valid = 2'b11;
         tick();
      end
      s_valid = 2'b00;
      #2 rst = 1'b0;
      #1;
      n_checks++; if (m_valid !== 2'b00) begin n_fail++; $display("FAIL async_m_valid got %b exp 00", m_valid); end
      n_checks++; if (s_ready !== 2'b11) begin n_fail++; $display("FAIL async_s_ready got %b exp 11", s_ready); end
      n_checks++; if (m_data !== 64'd0) begin n_fail++; $display("FAIL async_m_data got %h exp 0", m_data); end
      tick();
      rst = 1'b1;
      req_in = 2'b10; #1;
      n_checks++; if (io_in !== 32'sd0) begin n_fail++; $display("FAIL async_fifo_empty got %h exp 0", io_in); end
      tick();
      req_in = 2'b00;
   endtask

   initial begin
      rst = 1'b0; s_data = '0; s_valid = '0; req_in = '0; out_en = '0;
      io_out = '0; m_ready = '0; clr_err = 1'b0;
      test_reset();
      test_fill_drain();
      test_full_read_push();
      test_write_overrun();
      test_multi();
      test_handoff_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
